// File: rtl/cpu_mem_pkg.sv
// Shared data-memory definitions: memory size, arbiter states and the
// hash/accelerator control block base addresses.
package cpu_mem_pkg;
  localparam int MEM_SIZE = 65536;
  localparam logic [15:0] HCB_BASE = 16'h5000;
  localparam logic [15:0] ACB_BASE = 16'h6000;

  typedef enum logic [1:0] {IDLE, BURST, ACK} arb_state_t;
endpackage

// File: rtl/datamem_burst_seq.sv
// Splits an accelerator hash result into BURST_WORDS word writes, yielding
// to CPU writes for at most STARVE_MAX consecutive cycles.
module datamem_burst_seq
  import cpu_mem_pkg::*;
#(
  parameter int MEM_SIZE    = cpu_mem_pkg::MEM_SIZE,
  parameter int BURST_WORDS = 8,
  parameter int STARVE_MAX  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_req,
  input  logic [15:0]               start_addr,
  input  logic [32*BURST_WORDS-1:0] start_data,
  input  logic                      cpu_wr,
  output logic                      wr_en,
  output logic [15:0]               wr_addr,
  output logic [31:0]               wr_data,
  output logic                      busy,
  output logic                      ack,
  output logic                      range_err
);
  localparam int IDX_W = $clog2(BURST_WORDS);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  arb_state_t                state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [ST_W-1:0]           starve_q;
  logic [15:0]               base_q;
  logic [32*BURST_WORDS-1:0] data_q;
  logic                      cpu_wins;
  logic                      start_ok;

  assign start_ok  = (32'(start_addr) + 32'(4 * BURST_WORDS)) <= 32'(MEM_SIZE);
  assign range_err = (state_q == IDLE) && start_req && !start_ok;
  assign cpu_wins  = cpu_wr && (starve_q < ST_W'(STARVE_MAX));
  assign wr_en     = (state_q == BURST) && !cpu_wins;
  assign wr_addr   = base_q + (16'(idx_q) << 2);
  assign wr_data   = data_q[32*idx_q +: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      starve_q <= '0;
      base_q   <= '0;
      data_q   <= '0;
      busy     <= 1'b0;
      ack      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack <= 1'b0;
          if (start_req && start_ok) begin
            base_q   <= start_addr;
            data_q   <= start_data;
            idx_q    <= '0;
            starve_q <= '0;
            busy     <= 1'b1;
            state_q  <= BURST;
          end
        end
        BURST: begin
          if (cpu_wins) begin
            starve_q <= starve_q + 1'b1;
          end else begin
            starve_q <= '0;
            idx_q    <= idx_q + 1'b1;
            if (idx_q == IDX_W'(BURST_WORDS - 1)) begin
              ack     <= 1'b1;
              state_q <= ACK;
            end
          end
        end
        ACK: begin
          ack     <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/datamem_arbiter.sv
// Arbitrates the single data-memory write slot between CPU and SHA
// accelerator, range-checks all requests and registers read data.
module datamem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_SIZE    = cpu_mem_pkg::MEM_SIZE,
  parameter int BURST_WORDS = 8,
  parameter int STARVE_MAX  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [15:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic                      cpu_gnt,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_rvalid,
  input  logic                      acc_wr_req,
  input  logic [15:0]               acc_wr_addr,
  input  logic [32*BURST_WORDS-1:0] acc_wr_data,
  output logic                      acc_busy,
  output logic                      acc_wr_ack,
  input  logic                      acc_rd_req,
  input  logic [15:0]               acc_rd_addr,
  output logic [511:0]              acc_rd_data,
  output logic                      acc_rd_valid,
  output logic [15:0]               mem_cpu_addr,
  output logic [31:0]               mem_cpu_wrt_data,
  output logic                      mem_cpu_wrt_en,
  output logic                      mem_cpu_rd_en,
  input  logic [31:0]               mem_cpu_rd_data,
  output logic [15:0]               mem_accel_addr,
  output logic [31:0]               mem_accel_wrt_data,
  output logic                      mem_accel_wrt_en,
  output logic                      mem_accel_rd_en,
  input  logic [511:0]              mem_accel_rd_data,
  input  logic                      mem_err,
  output logic                      err
);
  logic        acc_wr_en;
  logic [15:0] acc_wr_word_addr;
  logic        burst_range_err;
  logic        cpu_ok;
  logic        acc_rd_ok;

  datamem_burst_seq #(
    .MEM_SIZE   (MEM_SIZE),
    .BURST_WORDS(BURST_WORDS),
    .STARVE_MAX (STARVE_MAX)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_req (acc_wr_req),
    .start_addr(acc_wr_addr),
    .start_data(acc_wr_data),
    .cpu_wr    (cpu_req && cpu_we),
    .wr_en     (acc_wr_en),
    .wr_addr   (acc_wr_word_addr),
    .wr_data   (mem_accel_wrt_data),
    .busy      (acc_busy),
    .ack       (acc_wr_ack),
    .range_err (burst_range_err)
  );

  assign cpu_ok    = 32'(cpu_addr) <= 32'(MEM_SIZE - 4);
  assign acc_rd_ok = 32'(acc_rd_addr) <= 32'(MEM_SIZE - 64);

  assign cpu_gnt          = cpu_req && !(cpu_we && acc_wr_en);
  assign mem_cpu_addr     = cpu_addr;
  assign mem_cpu_wrt_data = cpu_wdata;
  assign mem_cpu_wrt_en   = cpu_gnt && cpu_we && cpu_ok;
  assign mem_cpu_rd_en    = cpu_gnt && !cpu_we && cpu_ok;

  // The accelerator port has one address; a burst write owns it that cycle.
  assign mem_accel_wrt_en = acc_wr_en;
  assign mem_accel_addr   = acc_wr_en ? acc_wr_word_addr : acc_rd_addr;
  assign mem_accel_rd_en  = acc_rd_req && acc_rd_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata    <= '0;
      cpu_rvalid   <= 1'b0;
      acc_rd_data  <= '0;
      acc_rd_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      cpu_rvalid   <= cpu_gnt && !cpu_we;
      cpu_rdata    <= (cpu_gnt && !cpu_we && cpu_ok) ? mem_cpu_rd_data : '0;
      acc_rd_valid <= acc_rd_req;
      acc_rd_data  <= (acc_rd_req && acc_rd_ok) ? mem_accel_rd_data : '0;
      err          <= mem_err || burst_range_err
                      || (cpu_req && !cpu_ok)
                      || (acc_rd_req && !acc_rd_ok);
    end
  end
endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter with a word-array data memory model.
module tb_datamem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we;
  logic [15:0]  cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_gnt, cpu_rvalid;
  logic         acc_wr_req;
  logic [15:0]  acc_wr_addr;
  logic [255:0] acc_wr_data;
  logic         acc_busy, acc_wr_ack;
  logic         acc_rd_req;
  logic [15:0]  acc_rd_addr;
  logic [511:0] acc_rd_data;
  logic         acc_rd_valid;
  logic [15:0]  mem_cpu_addr, mem_accel_addr;
  logic [31:0]  mem_cpu_wrt_data, mem_cpu_rd_data, mem_accel_wrt_data;
  logic         mem_cpu_wrt_en, mem_cpu_rd_en, mem_accel_wrt_en, mem_accel_rd_en;
  logic [511:0] mem_accel_rd_data;
  logic         mem_err, err;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [16384];

  always #5 clk = ~clk;

  datamem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .acc_wr_req(acc_wr_req), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
    .acc_busy(acc_busy), .acc_wr_ack(acc_wr_ack),
    .acc_rd_req(acc_rd_req), .acc_rd_addr(acc_rd_addr),
    .acc_rd_data(acc_rd_data), .acc_rd_valid(acc_rd_valid),
    .mem_cpu_addr(mem_cpu_addr), .mem_cpu_wrt_data(mem_cpu_wrt_data),
    .mem_cpu_wrt_en(mem_cpu_wrt_en), .mem_cpu_rd_en(mem_cpu_rd_en),
    .mem_cpu_rd_data(mem_cpu_rd_data),
    .mem_accel_addr(mem_accel_addr), .mem_accel_wrt_data(mem_accel_wrt_data),
    .mem_accel_wrt_en(mem_accel_wrt_en), .mem_accel_rd_en(mem_accel_rd_en),
    .mem_accel_rd_data(mem_accel_rd_data),
    .mem_err(mem_err), .err(err)
  );

  // Data memory: synchronous writes on both ports, asynchronous reads.
  always @(posedge clk) begin
    if (mem_cpu_wrt_en)   mem[mem_cpu_addr[15:2]]   <= mem_cpu_wrt_data;
    if (mem_accel_wrt_en) mem[mem_accel_addr[15:2]] <= mem_accel_wrt_data;
  end
  assign mem_cpu_rd_data = mem[mem_cpu_addr[15:2]];
  always_comb begin
    mem_accel_rd_data = '0;
    for (int i = 0; i < 16; i++)
      mem_accel_rd_data[32*i +: 32] = mem[14'(int'(mem_accel_addr[15:2]) + i)];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    acc_wr_req = 0; acc_wr_addr = '0; acc_wr_data = '0;
    acc_rd_req = 0; acc_rd_addr = '0; mem_err = 0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
    cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    checks++;
    if ({acc_busy, acc_wr_ack, err, cpu_rvalid, acc_rd_valid, mem_accel_wrt_en,
         mem_cpu_wrt_en, cpu_gnt} !== 8'h00 || cpu_rdata !== '0 || acc_rd_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b ack=%b err=%b rvalid=%b want all 0",
               acc_busy, acc_wr_ack, err, cpu_rvalid);
    end
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_uncontended();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'(32'h1111_1111 * i);
    acc_wr_req = 1; acc_wr_addr = 16'h5000; acc_wr_data = d;
    tick();
    acc_wr_req = 0; acc_wr_data = {8{$urandom}};
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (mem_accel_wrt_en !== 1'b1 || mem_accel_addr !== 16'(16'h5000 + 4*k)
          || mem_accel_wrt_data !== 32'(32'h1111_1111 * k) || acc_wr_ack !== 1'b0) begin
        failures++;
        $display("FAIL burst_word%0d en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                 k, mem_accel_wrt_en, mem_accel_addr, mem_accel_wrt_data,
                 16'(16'h5000 + 4*k), 32'(32'h1111_1111 * k));
      end
      tick();
    end
    checks++;
    if (acc_wr_ack !== 1'b1 || acc_busy !== 1'b1 || mem_accel_wrt_en !== 1'b0) begin
      failures++;
      $display("FAIL burst_ack ack=%b busy=%b en=%b want 1 1 0", acc_wr_ack, acc_busy, mem_accel_wrt_en);
    end
    tick();
    checks++;
    if (acc_wr_ack !== 1'b0 || acc_busy !== 1'b0) begin
      failures++;
      $display("FAIL burst_idle ack=%b busy=%b want 0 0", acc_wr_ack, acc_busy);
    end
    acc_rd_req = 1; acc_rd_addr = 16'h5000;
    #1;
    checks++;
    if (mem_accel_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL acc_rd_en got=%b want 1", mem_accel_rd_en);
    end
    tick();
    acc_rd_req = 0;
    checks++;
    if (acc_rd_valid !== 1'b1 || acc_rd_data[255:0] !== d) begin
      failures++;
      $display("FAIL acc_rd_burst valid=%b data=%h want 1 %h", acc_rd_valid, acc_rd_data[255:0], d);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] w [8];
    logic [255:0] d;
    for (int i = 0; i < 8; i++) begin
      w[i] = $urandom;
      d[32*i +: 32] = w[i];
    end
    acc_wr_req = 1; acc_wr_addr = 16'h7000; acc_wr_data = d;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h8000; cpu_wdata = $urandom;
    tick();
    acc_wr_req = 0;
    // CPU holds the slot for 4 cycles, then the accelerator gets one word.
    for (int k = 0; k < 40; k++) begin
      logic exp_acc;
      exp_acc = (k % 5) == 4;
      cpu_addr = 16'(16'h8000 + 4 * $urandom_range(0, 63));
      cpu_wdata = $urandom;
      #1;
      checks++;
      if (mem_accel_wrt_en !== exp_acc || cpu_gnt !== !exp_acc
          || (mem_accel_wrt_en && mem_cpu_wrt_en)
          || (exp_acc && (mem_accel_addr !== 16'(16'h7000 + 4*(k/5))
                          || mem_accel_wrt_data !== w[k/5]))) begin
        failures++;
        $display("FAIL starve_cycle%0d acc_en=%b gnt=%b cpu_en=%b addr=%h want acc_en=%b gnt=%b",
                 k, mem_accel_wrt_en, cpu_gnt, mem_cpu_wrt_en, mem_accel_addr, exp_acc, !exp_acc);
      end
      tick();
    end
    cpu_req = 0; cpu_we = 0;
    checks++;
    if (acc_wr_ack !== 1'b1) begin
      failures++;
      $display("FAIL starve_ack got=%b want 1 after 40 cycles", acc_wr_ack);
    end
    tick();
    checks++;
    if (acc_busy !== 1'b0) begin
      failures++;
      $display("FAIL starve_idle busy=%b want 0", acc_busy);
    end
  endtask

  task automatic test_read_latency();
    cpu_write(16'h9000, 32'hDEAD_BEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h9000;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || mem_cpu_rd_en !== 1'b1 || cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_grant gnt=%b rd_en=%b rvalid=%b want 1 1 0", cpu_gnt, mem_cpu_rd_en, cpu_rvalid);
    end
    tick();
    cpu_req = 0;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd_latency rvalid=%b rdata=%h want 1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    tick();
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_pulse rvalid=%b want 0", cpu_rvalid);
    end
  endtask

  task automatic test_out_of_range();
    int acks = 0;
    acc_wr_req = 1; acc_wr_addr = 16'hFFF0; acc_wr_data = {8{$urandom}};
    tick();
    acc_wr_req = 0;
    checks++;
    if (err !== 1'b1 || acc_busy !== 1'b0) begin
      failures++;
      $display("FAIL wr_oor err=%b busy=%b want 1 0", err, acc_busy);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      acks += int'(acc_wr_ack) + int'(acc_busy);
    end
    checks++;
    if (acks != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL wr_oor_quiet ack_or_busy_cycles=%0d err=%b want 0 0", acks, err);
    end
    acc_rd_req = 1; acc_rd_addr = 16'hFFC1;
    #1;
    checks++;
    if (mem_accel_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL rd_oor_en got=%b want 0", mem_accel_rd_en);
    end
    tick();
    acc_rd_req = 0;
    checks++;
    if (err !== 1'b1 || acc_rd_valid !== 1'b1 || acc_rd_data !== '0) begin
      failures++;
      $display("FAIL rd_oor err=%b valid=%b data_nonzero=%b want 1 1 0", err, acc_rd_valid, |acc_rd_data);
    end
    acc_rd_req = 1; acc_rd_addr = 16'hFFC0;
    #1;
    checks++;
    if (mem_accel_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL rd_edge_en got=%b want 1", mem_accel_rd_en);
    end
    tick();
    acc_rd_req = 0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL rd_edge_err got=%b want 0", err);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'hFFFD;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || mem_cpu_rd_en !== 1'b0 || mem_cpu_wrt_en !== 1'b0) begin
      failures++;
      $display("FAIL cpu_oor_gnt gnt=%b rd_en=%b wr_en=%b want 1 0 0", cpu_gnt, mem_cpu_rd_en, mem_cpu_wrt_en);
    end
    tick();
    cpu_req = 0;
    checks++;
    if (err !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL cpu_oor err=%b rvalid=%b rdata=%h want 1 1 0", err, cpu_rvalid, cpu_rdata);
    end
    mem_err = 1;
    tick();
    mem_err = 0;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL mem_err err=%b want 1", err);
    end
    tick();
    // Highest legal burst base ends exactly at the top of memory.
    acc_wr_req = 1; acc_wr_addr = 16'hFFE0; acc_wr_data = {8{$urandom}};
    tick();
    acc_wr_req = 0;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (err !== 1'b0 || acc_wr_ack !== 1'b1) begin
      failures++;
      $display("FAIL wr_edge err=%b ack=%b want 0 1", err, acc_wr_ack);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] d;
    int acks = 0;
    for (int i = 0; i < 8; i++) cpu_write(16'(16'h5000 + 4*i), 32'h0);
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom | 32'h1;
    acc_wr_req = 1; acc_wr_addr = 16'h5000; acc_wr_data = d;
    tick();
    acc_wr_req = 0;
    tick(); tick(); tick();
    rst_n = 0;
    #1;
    checks++;
    if ({acc_busy, acc_wr_ack, err, cpu_rvalid, acc_rd_valid, mem_accel_wrt_en} !== 6'h00) begin
      failures++;
      $display("FAIL midrst_outputs busy=%b ack=%b en=%b want 0 0 0", acc_busy, acc_wr_ack, mem_accel_wrt_en);
    end
    tick();
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      acks += int'(acc_wr_ack) + int'(acc_busy);
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL midrst_noack ack_or_busy_cycles=%0d want 0", acks);
    end
    acc_rd_req = 1; acc_rd_addr = 16'h5000;
    tick();
    acc_rd_req = 0;
    checks++;
    if (acc_rd_data[95:0] !== d[95:0] || acc_rd_data[127:96] !== 32'h0) begin
      failures++;
      $display("FAIL midrst_mem got=%h want %h with word3=0", acc_rd_data[127:0], {32'h0, d[95:0]});
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] pre [4];
    int j, prev_j;
    prev_j = 0;
    for (int i = 0; i < 4; i++) begin
      pre[i] = $urandom;
      cpu_write(16'(16'hA000 + 4*i), pre[i]);
    end
    acc_wr_req = 1; acc_wr_addr = 16'h6000; acc_wr_data = {8{$urandom}};
    tick();
    acc_wr_req = 0;
    for (int k = 0; k < 8; k++) begin
      j = $urandom_range(0, 3);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'(16'hA000 + 4*j);
      #1;
      checks++;
      if (cpu_gnt !== 1'b1 || mem_accel_wrt_en !== 1'b1
          || (k > 0 && (cpu_rvalid !== 1'b1 || cpu_rdata !== pre[prev_j]))) begin
        failures++;
        $display("FAIL concurrent%0d gnt=%b acc_en=%b rdata=%h want 1 1 %h",
                 k, cpu_gnt, mem_accel_wrt_en, cpu_rdata, pre[prev_j]);
      end
      prev_j = j;
      tick();
    end
    cpu_req = 0;
    checks++;
    if (acc_wr_ack !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== pre[prev_j]) begin
      failures++;
      $display("FAIL concurrent_end ack=%b rvalid=%b rdata=%h want 1 1 %h",
               acc_wr_ack, cpu_rvalid, cpu_rdata, pre[prev_j]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_uncontended();
    test_starvation();
    test_read_latency();
    test_out_of_range();
    test_reset_mid_burst();
    test_concurrent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Arbiter and write sequencer in front of `cpu_datamem`.
- Shares the single-write-per-cycle data memory between the CPU and the SHA accelerator, so the two write ports are never asserted together.
- Breaks a 32-byte accelerator hash result into eight 4-byte memory writes.
- Registers CPU and accelerator read data.
- Sits between the CPU load/store stage, the accelerator result/fetch interfaces and the `cpu_datamem` ports.

## Interface
Parameters:
- `MEM_SIZE`, 65536: data memory size in bytes.
- `BURST_WORDS`, 8: 32-bit words per accelerator write burst.
- `STARVE_MAX`, 4: consecutive CPU-won write cycles before the accelerator is forced a slot.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cpu_req`  in  1: CPU access request.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  16: byte address.
- `cpu_wdata`  in  32: write data.
- `cpu_gnt`  out  1: combinational; access performed this cycle.
- `cpu_rdata`  out  32: registered read data.
- `cpu_rvalid`  out  1: one-cycle pulse, `cpu_rdata` valid.
- `acc_wr_req`  in  1: start write burst.
- `acc_wr_addr`  in  16: burst base byte address.
- `acc_wr_data`  in  256: burst payload; word i = `[32*i +: 32]`.
- `acc_busy`  out  1: burst in progress.
- `acc_wr_ack`  out  1: one-cycle pulse, burst complete.
- `acc_rd_req`  in  1: 64-byte read request.
- `acc_rd_addr`  in  16: read base address.
- `acc_rd_data`  out  512: registered read data.
- `acc_rd_valid`  out  1: one-cycle pulse.
- `mem_cpu_addr`, `mem_cpu_wrt_data`, `mem_cpu_wrt_en`, `mem_cpu_rd_en`  out  16/32/1/1: memory CPU port.
- `mem_cpu_rd_data`  in  32: memory CPU read data.
- `mem_accel_addr`, `mem_accel_wrt_data`, `mem_accel_wrt_en`, `mem_accel_rd_en`  out  16/32/1/1: memory accelerator port.
- `mem_accel_rd_data`  in  512: memory accelerator read data.
- `mem_err`  in  1: memory error.
- `err`  out  1: one-cycle error pulse.

## Operation
FSM states: `IDLE`, `BURST`, `ACK`.
- **IDLE:**
  - If `acc_wr_req` is high and `acc_wr_addr + 4*BURST_WORDS <= MEM_SIZE`: latch address and data, idx=0, starve=0, go to `BURST`.
  - If out of range: pulse `err`, stay in `IDLE`, no ack.
- **BURST:** an accelerator word is pending every cycle.
  - CPU wins if `cpu_req & cpu_we & (starve < STARVE_MAX)`; then starve++.
  - Otherwise the accelerator writes: `mem_accel_wrt_en`=1, `mem_accel_addr` = base+4*idx, data = word idx, idx++, starve=0.
  - After the write with idx = `BURST_WORDS`-1, go to `ACK`.
- **ACK:** `acc_wr_ack`=1 for one cycle, then `IDLE`.
- `acc_wr_req` is ignored while `acc_busy` (state != `IDLE`).

CPU grant:
- `cpu_gnt` = `cpu_req` & ~(`cpu_we` & accelerator writing this cycle).
- CPU reads are always granted; the memory read ports are independent.
- A granted CPU write drives `mem_cpu_wrt_en`; a granted read drives `mem_cpu_rd_en`.

Range checks and errors:
- A CPU request with `cpu_addr > MEM_SIZE-4`: `cpu_gnt`=1, no memory enable driven, `err` pulses next cycle, and for a read `cpu_rdata`=0 with `cpu_rvalid` pulse.
- `acc_rd_req` is honoured every cycle it is high; `mem_accel_rd_en` is driven combinationally.
- An accelerator read with `acc_rd_addr > MEM_SIZE-64` drives no enable and pulses `err`.
- `err` also pulses one cycle after any `mem_err`.

Invariants and ordering:
- `mem_cpu_wrt_en & mem_accel_wrt_en` is never 1.
- No read-after-write ordering between requesters: a CPU read of a burst target returns whatever is in memory at that cycle.

## Timing
Reset: all outputs 0, state `IDLE`, idx=0, starve=0.

Reset asserted mid-burst:
- The burst is abandoned immediately; no ack is issued.
- Words already written stay in memory.

Uncontended burst, with the request sampled at edge E0:
- Writes occur in the 8 cycles following E0.
- `acc_wr_ack` is high in the cycle after E8.
- The block returns to `IDLE` at E9.

Contention:
- Each CPU write that wins adds one cycle to the burst.
- Worst-case burst length = `BURST_WORDS`*(`STARVE_MAX`+1) cycles.

Read latency:
- CPU: `cpu_rdata`/`cpu_rvalid` are registered one cycle after the granting cycle.
- Accelerator: `acc_rd_data`/`acc_rd_valid` likewise, one cycle after the request cycle.

Simultaneous events:
- A CPU read and an accelerator burst write in the same cycle both proceed.
- A CPU write and an accelerator read in the same cycle both proceed.

## Structure
- Shared package `cpu_mem_pkg`:
  - `MEM_SIZE`
  - the `arb_state_t` enum (`IDLE`/`BURST`/`ACK`)
  - the HCB/ACB base-address localparams
- One natural sub-module: `datamem_burst_seq`, holding the idx/starve counters and the FSM.
- CPU grant and read registers stay in the top level.

## Test plan
- **Uncontended burst:** reset, then burst at `acc_wr_addr`=0x5000 with word i = 0x1111_1111*i. Required: 8 consecutive `mem_accel_wrt_en` cycles at 0x5000..0x501C, then `acc_wr_ack` on cycle 9, then `acc_busy`=0.
- **Starvation:** CPU writes every cycle during the burst. Required: CPU granted 4 cycles, then 1 accelerator word, repeating; burst done in 40 cycles; the two write enables are never both high.
- **Read latency:** CPU reads 0x9000 after writing 0xDEADBEEF there. Required: `cpu_rvalid` one cycle after the grant with `cpu_rdata`=0xDEADBEEF.
- **Out-of-range requests:** burst at 0xFFF0 gives an `err` pulse, no ack, and stays `IDLE`. Accelerator read at 0xFFC1 gives an `err` pulse and `acc_rd_data`=0.
- **Reset mid-burst:** assert `rst_n` low after 3 words. Required: outputs 0, state `IDLE`, no ack; 0x5000..0x5008 written and 0x500C untouched.
- **Concurrent access:** CPU read concurrent with the burst. Required: `cpu_gnt`=1 every cycle, and the burst completes in 8 cycles.
